// File: rtl/embcpumem_nios2_qsys_0_oci_dct_packer_if.sv
// Trace-atom packer bus: atom input handshake, packed-word output handshake
// and session-end status.
interface embcpumem_nios2_qsys_0_oci_dct_packer_if;
  logic        atom_valid;
  logic [2:0]  atom_data;
  logic        atom_ready;
  logic        flush;
  logic        end_req;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid;
  logic        dct_ready;
  logic        test_ending;
  logic        test_has_ended;

  modport master (
    output atom_valid, atom_data, flush, end_req, dct_ready,
    input  atom_ready, dct_buffer, dct_count, dct_valid, test_ending, test_has_ended
  );

  modport slave (
    input  atom_valid, atom_data, flush, end_req, dct_ready,
    output atom_ready, dct_buffer, dct_count, dct_valid, test_ending, test_has_ended
  );
endinterface

// File: rtl/embcpumem_nios2_qsys_0_oci_dct_packer.sv
// Packs 3-bit trace atoms into 30-bit words of up to ten atoms, with flush,
// idle auto-flush and an orderly end-of-session drain.
module embcpumem_nios2_qsys_0_oci_dct_packer #(
  parameter int IDLE_FLUSH_CYCLES = 64
) (
  input  logic clk,
  input  logic reset_n,
  embcpumem_nios2_qsys_0_oci_dct_packer_if.slave bus
);

  typedef enum logic [1:0] {RUN = 2'd0, ENDING = 2'd1, ENDED = 2'd2} state_e;

  localparam int TW = (IDLE_FLUSH_CYCLES > 1) ? $clog2(IDLE_FLUSH_CYCLES + 1) : 1;
  localparam logic [TW-1:0] IDLE_LIM = TW'(IDLE_FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [29:0] acc_q, acc_d;
  logic [3:0]  acc_cnt_q, acc_cnt_d;
  logic        close_pend_q, close_pend_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [29:0] buf_q, buf_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        vld_q, vld_d;

  logic slot_free, accept, close_req, close_fire, idle_hit, pend_set;
  logic atom_ready_int, ending_int, ended_int;

  assign slot_free  = !vld_q || bus.dct_ready;
  assign accept     = bus.atom_valid && atom_ready_int;
  assign close_req  = (acc_cnt_q == 4'd10) || (close_pend_q && (acc_cnt_q != 4'd0));
  assign close_fire = close_req && slot_free;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (bus.end_req) state_d = ENDING;
      ENDING:  if ((acc_cnt_q == 4'd0) && !vld_q) state_d = ENDED;
      ENDED:   state_d = ENDED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    atom_ready_int = 1'b0;
    ending_int     = 1'b0;
    ended_int      = 1'b0;
    unique case (state_q)
      RUN:     atom_ready_int = (acc_cnt_q < 4'd10) || slot_free;
      ENDING:  ending_int = 1'b1;
      ENDED:   begin
        ending_int = 1'b1;
        ended_int  = 1'b1;
      end
      default: atom_ready_int = 1'b0;
    endcase
  end

  // A full word closing in the same cycle as an accept frees slot 0 for that atom.
  always_comb begin
    acc_d     = acc_q;
    acc_cnt_d = acc_cnt_q;
    if (close_fire) begin
      acc_d     = '0;
      acc_cnt_d = 4'd0;
    end
    if (accept) begin
      for (int k = 0; k < 10; k++) begin
        if (4'(k) == acc_cnt_d) acc_d[3*k +: 3] = bus.atom_data;
      end
      acc_cnt_d = acc_cnt_d + 4'd1;
    end

    buf_d = buf_q;
    cnt_d = cnt_q;
    vld_d = vld_q;
    if (close_fire) begin
      buf_d = acc_q;
      cnt_d = acc_cnt_q;
      vld_d = 1'b1;
    end else if (bus.dct_ready) begin
      vld_d = 1'b0;
    end

    timer_d = timer_q;
    if ((IDLE_FLUSH_CYCLES == 0) || accept || close_fire || (acc_cnt_q == 4'd0)) begin
      timer_d = '0;
    end else if (timer_q != IDLE_LIM) begin
      timer_d = timer_q + TW'(1);
    end
    idle_hit = (IDLE_FLUSH_CYCLES != 0) && (timer_d == IDLE_LIM);

    // A close request against an empty accumulator is dropped so no empty word can form.
    pend_set     = bus.flush || (bus.end_req && (state_q == RUN)) || idle_hit;
    close_pend_d = ((close_pend_q && !close_fire) || pend_set) && (acc_cnt_d != 4'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q        <= '0;
      acc_cnt_q    <= 4'd0;
      close_pend_q <= 1'b0;
      timer_q      <= '0;
      buf_q        <= '0;
      cnt_q        <= 4'd0;
      vld_q        <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      close_pend_q <= close_pend_d;
      timer_q      <= timer_d;
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      vld_q        <= vld_d;
    end
  end

  assign bus.atom_ready     = atom_ready_int && reset_n;
  assign bus.dct_buffer     = buf_q;
  assign bus.dct_count      = cnt_q;
  assign bus.dct_valid      = vld_q;
  assign bus.test_ending    = ending_int;
  assign bus.test_has_ended = ended_int;

endmodule

// File: tb/tb_embcpumem_nios2_qsys_0_oci_dct_packer.sv
// Bench for the trace-atom packer: vector table, directed corner sequences
// and a randomized run scored against an atom-order model.
module tb_embcpumem_nios2_qsys_0_oci_dct_packer;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  embcpumem_nios2_qsys_0_oci_dct_packer_if bus();

  embcpumem_nios2_qsys_0_oci_dct_packer #(.IDLE_FLUSH_CYCLES(64)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct packed {
    logic [3:0]  cnt;
    logic [29:0] buff;
  } word_t;

  typedef struct {
    int          n;
    int          a[10];
    logic [29:0] exp_buf;
  } vec_t;

  int checks = 0;
  int failures = 0;

  logic [2:0] seen_q[$];
  word_t      words_q[$];

  logic        hold_prev = 1'b0;
  logic [29:0] hold_buf;
  logic [3:0]  hold_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: records accepted atoms and delivered words, checks held words stay put.
  always @(negedge clk) begin
    if (!reset_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev)
        check("hold_stable", 64'({bus.dct_valid, bus.dct_count, bus.dct_buffer}),
              64'({1'b1, hold_cnt, hold_buf}));
      if (bus.dct_valid && bus.dct_ready) words_q.push_back({bus.dct_count, bus.dct_buffer});
      if (bus.atom_valid && bus.atom_ready) seen_q.push_back(bus.atom_data);
      hold_prev = bus.dct_valid && !bus.dct_ready;
      hold_buf  = bus.dct_buffer;
      hold_cnt  = bus.dct_count;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.atom_valid = 1'b0;
    bus.atom_data  = 3'd0;
    bus.flush      = 1'b0;
    bus.end_req    = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_outputs_zero",
          64'({bus.atom_ready, bus.dct_buffer, bus.dct_count, bus.dct_valid,
               bus.test_ending, bus.test_has_ended}), 64'd0);
    idle_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check("ready_after_reset", 64'(bus.atom_ready), 64'd1);
    check("not_ending_after_reset", 64'({bus.test_ending, bus.test_has_ended}), 64'd0);
    seen_q.delete();
    words_q.delete();
  endtask

  task automatic send(input logic [2:0] d, input logic fl, input logic er);
    bit got;
    got = 1'b0;
    bus.atom_valid = 1'b1;
    bus.atom_data  = d;
    bus.flush      = fl;
    bus.end_req    = er;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = bus.atom_ready;
      tick();
    end
    idle_inputs();
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: atom %0d never accepted", d);
    end
  endtask

  task automatic wait_word(input int budget, input string name, output word_t w, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    w = '0;
    for (int i = 0; i <= budget; i++) begin
      if (words_q.size() > 0) begin
        ok = 1'b1;
        break;
      end
      if (i < budget) begin
        tick();
        waited++;
      end
    end
    if (ok) begin
      w = words_q.pop_front();
    end else begin
      checks++;
      failures++;
      $display("FAIL %s: no word within %0d cycles", name, budget);
    end
  endtask

  // Reference: a word must be the next dct_count accepted atoms, in order, atom0 at LSB.
  task automatic check_sb(input string name, input word_t w);
    logic [29:0] exp;
    int n;
    exp = '0;
    n = int'(w.cnt);
    check({name, "_count_range"}, 64'((n >= 1) && (n <= 10)), 64'd1);
    if (n >= 1 && n <= 10 && seen_q.size() >= n) begin
      for (int k = 0; k < n; k++) exp[3*k +: 3] = seen_q.pop_front();
    end
    check(name, 64'(w.buff), 64'(exp));
  endtask

  vec_t  tbl[7];
  word_t w;
  int    waited, n_acc, bubbles;
  bit    got;

  initial begin
    idle_inputs();
    bus.dct_ready = 1'b1;

    tbl[0].n = 10; tbl[0].a = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1}; tbl[0].exp_buf = 30'o1076543210;
    tbl[1].n = 10; tbl[1].a = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7}; tbl[1].exp_buf = 30'o7777777777;
    tbl[2].n = 10; tbl[2].a = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}; tbl[2].exp_buf = 30'o0;
    tbl[3].n = 10; tbl[3].a = '{3, 1, 4, 1, 5, 2, 6, 5, 3, 5}; tbl[3].exp_buf = 30'o5356251413;
    tbl[4].n = 3;  tbl[4].a = '{2, 4, 6, 0, 0, 0, 0, 0, 0, 0}; tbl[4].exp_buf = 30'o642;
    tbl[5].n = 1;  tbl[5].a = '{7, 0, 0, 0, 0, 0, 0, 0, 0, 0}; tbl[5].exp_buf = 30'o7;
    tbl[6].n = 7;  tbl[6].a = '{1, 2, 3, 4, 5, 6, 7, 0, 0, 0}; tbl[6].exp_buf = 30'o7654321;

    do_reset();

    // Vector table: full words back-to-back, partial words closed by flush on the last atom.
    for (int v = 0; v < 7; v++) begin
      for (int j = 0; j < tbl[v].n; j++)
        send(3'(tbl[v].a[j]), (j == tbl[v].n - 1) && (tbl[v].n < 10), 1'b0);
      wait_word(20, $sformatf("vec%0d_word", v), w, waited);
      check($sformatf("vec%0d_count", v), 64'(w.cnt), 64'(tbl[v].n));
      check($sformatf("vec%0d_buffer", v), 64'(w.buff), 64'(tbl[v].exp_buf));
      seen_q.delete();
    end

    // Twelve 5s: no bubble at the word boundary, remainder leaves by idle flush.
    bubbles = 0;
    bus.atom_valid = 1'b1;
    bus.atom_data  = 3'd5;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!bus.atom_ready) bubbles++;
      tick();
    end
    idle_inputs();
    check("twelve_no_bubble", 64'(bubbles), 64'd0);
    wait_word(20, "twelve_w1", w, waited);
    check("twelve_w1_count", 64'(w.cnt), 64'd10);
    check("twelve_w1_buffer", 64'(w.buff), 64'(30'o5555555555));
    wait_word(120, "twelve_w2", w, waited);
    check("twelve_w2_count", 64'(w.cnt), 64'd2);
    check("twelve_w2_buffer", 64'(w.buff), 64'(30'o55));
    check("idle_flush_delay", 64'((waited >= 64) && (waited <= 68)), 64'd1);
    seen_q.delete();

    // Backpressure: 20 atoms fit (slot + accumulator), the 21st waits.
    bus.dct_ready  = 1'b0;
    n_acc = 0;
    bus.atom_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (n_acc < 20) bus.atom_data = 3'($urandom);
      @(negedge clk);
      if (bus.atom_ready) n_acc++;
      tick();
    end
    check("bp_accepted", 64'(n_acc), 64'd20);
    check("bp_ready_low", 64'(bus.atom_ready), 64'd0);
    check("bp_held_word", 64'({bus.dct_valid, bus.dct_count}), 64'({1'b1, 4'd10}));
    bus.dct_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus.atom_ready) begin
        got = 1'b1;
        n_acc++;
      end
      tick();
    end
    idle_inputs();
    check("bp_accepted_21", 64'(n_acc), 64'd21);
    for (int k = 0; k < 3; k++) begin
      wait_word((k == 2) ? 100 : 20, $sformatf("bp_w%0d", k), w, waited);
      check($sformatf("bp_w%0d_count", k), 64'(w.cnt), (k == 2) ? 64'd1 : 64'd10);
      check_sb($sformatf("bp_w%0d_data", k), w);
    end

    // Flush with atom 3; then a flush on an empty accumulator must not arm a close.
    seen_q.delete();
    send(3'd1, 1'b0, 1'b0);
    send(3'd2, 1'b0, 1'b0);
    send(3'd3, 1'b1, 1'b0);
    wait_word(20, "flush3", w, waited);
    check("flush3_count", 64'(w.cnt), 64'd3);
    check("flush3_buffer", 64'(w.buff), 64'(30'o321));
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    repeat (20) tick();
    check("empty_flush_no_word", 64'(words_q.size()), 64'd0);
    send(3'd4, 1'b0, 1'b0);
    repeat (10) tick();
    check("no_stale_close", 64'(words_q.size()), 64'd0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    wait_word(20, "flush1", w, waited);
    check("flush1_word", 64'(w), 64'({4'd1, 30'o4}));

    // End of session with the final word held off by the consumer.
    do_reset();
    bus.dct_ready = 1'b0;
    send(3'd1, 1'b0, 1'b0);
    send(3'd2, 1'b0, 1'b0);
    send(3'd3, 1'b0, 1'b0);
    send(3'd4, 1'b0, 1'b1);
    bus.atom_valid = 1'b1;
    bus.atom_data  = 3'd6;
    repeat (5) tick();
    bus.atom_valid = 1'b0;
    check("end_status", 64'({bus.test_ending, bus.atom_ready, bus.test_has_ended}), 64'b100);
    check("end_word_pending", 64'({bus.dct_valid, bus.dct_count}), 64'({1'b1, 4'd4}));
    check("end_no_more_atoms", 64'(seen_q.size()), 64'd4);
    bus.dct_ready = 1'b1;
    tick();
    bus.dct_ready = 1'b0;
    check("end_not_yet", 64'(bus.test_has_ended), 64'd0);
    tick();
    check("end_has_ended", 64'({bus.test_ending, bus.test_has_ended}), 64'b11);
    wait_word(5, "end_word", w, waited);
    check("end_word", 64'(w), 64'({4'd4, 30'o4321}));
    bus.end_req = 1'b1;
    bus.atom_valid = 1'b1;
    repeat (5) tick();
    idle_inputs();
    check("ended_terminal", 64'({bus.test_has_ended, bus.atom_ready}), 64'b10);

    // Reset mid-word with a word pending, then a clean word afterwards.
    do_reset();
    bus.dct_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(3'($urandom), 1'b0, 1'b0);
    check("pre_reset_pending", 64'(bus.dct_valid), 64'd1);
    do_reset();
    bus.dct_ready = 1'b1;
    for (int j = 0; j < 10; j++) send(3'(tbl[0].a[j]), 1'b0, 1'b0);
    wait_word(20, "post_reset", w, waited);
    check("post_reset_word", 64'(w), 64'({4'd10, 30'o1076543210}));

    // Randomized traffic against the atom-order model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bus.atom_valid = ($urandom_range(0, 3) != 0);
      bus.atom_data  = 3'($urandom);
      bus.dct_ready  = ($urandom_range(0, 3) != 0);
      bus.flush      = ($urandom_range(0, 31) == 0);
      tick();
      while (words_q.size() > 0) check_sb("rand_word", words_q.pop_front());
    end
    idle_inputs();
    bus.dct_ready = 1'b1;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    repeat (30) begin
      tick();
      while (words_q.size() > 0) check_sb("rand_drain", words_q.pop_front());
    end
    check("rand_all_delivered", 64'(seen_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
